ctrl: RTL and testbench

- Pipeline control unit at the consuming end of the execute stage's control interface.
- Accepts branch/jump redirect requests (jump_en2ctrl/jump_addr2ctrl) and hold requests (hold2ctrl) from ex.
- Arbitrates an external bus-hold handshake.
- Drives the registered PC redirect, a multi-cycle pipeline flush, and the pipeline hold flag.

---
 rtl/ctrl_pkg.sv | 20 ++
 rtl/ctrl_if.sv | 30 +++
 rtl/ctrl_stats.sv | 38 +++
 rtl/ctrl.sv | 113 +++++++++++
 tb/tb_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl_pkg : shared types and constants for the pipeline control   |
// | unit (state encoding, flush counter width, default flush length) |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        BUS   = 2'd2
    } state_e;

    localparam int unsigned c_FLUSH_CNT_W      = 4;
    localparam int unsigned c_FLUSH_CYCLES_DEF = 2;
    localparam int unsigned c_STAT_W           = 32;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl_if : execute-stage / bus-master side of the control unit    |
// | (redirect, hold, bus-hold handshake and pipeline control).       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] jump_addr2ctrl;
    logic              jump_en2ctrl;
    logic              hold2ctrl;
    logic              bus_hold_req;
    logic              bus_hold_ack;
    logic              jump_en2pc;
    logic [ADDR_W-1:0] jump_addr2pc;
    logic              flush2pipe;
    logic              hold_flag;

    modport master (
        output jump_addr2ctrl, jump_en2ctrl, hold2ctrl, bus_hold_req,
        input  bus_hold_ack, jump_en2pc, jump_addr2pc, flush2pipe, hold_flag
    );

    modport slave (
        input  jump_addr2ctrl, jump_en2ctrl, hold2ctrl, bus_hold_req,
        output bus_hold_ack, jump_en2pc, jump_addr2pc, flush2pipe, hold_flag
    );
endinterface : ctrl_if
`default_nettype wire

// File: rtl/ctrl_stats.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl_stats : wrapping redirect / hold-cycle event counters.      |
// | Instantiated by ctrl only when CTRL_STATS_EN is defined.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ctrl_stats
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_en_i,
    input  logic                hold_i,
    output logic [c_STAT_W-1:0] redirect_cnt_o,
    output logic [c_STAT_W-1:0] hold_cnt_o
);
    logic [c_STAT_W-1:0] redirect_cnt_q;
    logic [c_STAT_W-1:0] hold_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            hold_cnt_q     <= '0;
        end else begin
            if (jump_en_i) begin
                redirect_cnt_q <= redirect_cnt_q + c_STAT_W'(1);
            end
            if (hold_i) begin
                hold_cnt_q <= hold_cnt_q + c_STAT_W'(1);
            end
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign hold_cnt_o     = hold_cnt_q;

endmodule : ctrl_stats
`default_nettype wire

// File: rtl/ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl : pipeline control unit - registered PC redirect, multi-    |
// | cycle flush, bus-hold arbitration and combinational hold flag.   |
// | Optional event counters when CTRL_STATS_EN is defined.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = c_FLUSH_CYCLES_DEF,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_if.slave        io
`ifdef CTRL_STATS_EN
    ,
    output logic [c_STAT_W-1:0] redirect_cnt,
    output logic [c_STAT_W-1:0] hold_cnt
`endif
);
    localparam logic [c_FLUSH_CNT_W-1:0] c_CNT_LOAD = c_FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [c_FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                     jump_en_q, jump_en_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     flush_q, flush_d;
    logic                     ack_q, ack_d;
    logic                     hold_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            jump_en_q <= 1'b0;
            addr_q    <= '0;
            flush_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            jump_en_q <= jump_en_d;
            addr_q    <= addr_d;
            flush_q   <= flush_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        jump_en_d = 1'b0;
        addr_d    = addr_q;
        flush_d   = 1'b0;
        ack_d     = 1'b0;
        case (state_q)
            RUN: begin
                // Redirect beats a simultaneous bus request; the request waits.
                if (io.jump_en2ctrl) begin
                    jump_en_d = 1'b1;
                    addr_d    = io.jump_addr2ctrl;
                    flush_d   = 1'b1;
                    cnt_d     = c_CNT_LOAD;
                    state_d   = FLUSH;
                end else if (io.bus_hold_req) begin
                    ack_d   = 1'b1;
                    state_d = BUS;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d   = cnt_q - c_FLUSH_CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            BUS: begin
                if (io.bus_hold_req) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign hold_flag = (io.hold2ctrl & ~io.jump_en2ctrl & ~flush_q) | ack_q;

    assign io.hold_flag    = hold_flag;
    assign io.jump_en2pc   = jump_en_q;
    assign io.jump_addr2pc = addr_q;
    assign io.flush2pipe   = flush_q;
    assign io.bus_hold_ack = ack_q;

`ifdef CTRL_STATS_EN
    ctrl_stats u_stats (
        .clk            (clk),
        .rst            (rst),
        .jump_en_i      (jump_en_q),
        .hold_i         (hold_flag),
        .redirect_cnt_o (redirect_cnt),
        .hold_cnt_o     (hold_cnt)
    );
`endif

endmodule : ctrl
`default_nettype wire

// File: tb/tb_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ctrl : self-checking bench for ctrl - directed scenarios plus |
// | randomized traffic against a behavioural model. CTRL_STATS_EN    |
// | adds the counter checks. Rev 1.0                                 |
// +------------------------------------------------------------------+
module tb_ctrl;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ctrl_if #(.ADDR_W(32)) bif ();

`ifdef CTRL_STATS_EN
    logic [31:0] redirect_cnt, hold_cnt;
`endif

    ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bif)
`ifdef CTRL_STATS_EN
        ,
        .redirect_cnt (redirect_cnt),
        .hold_cnt     (hold_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: flush_left = flush cycles still to be shown.
    int          m_flush_left = 0;
    bit          m_jump_en    = 1'b0;
    logic [31:0] m_addr       = '0;
    bit          m_ack        = 1'b0;
    logic [31:0] m_rcnt       = '0;
    logic [31:0] m_hcnt       = '0;

    function automatic logic exp_hold();
        return (bif.hold2ctrl && !bif.jump_en2ctrl && !(m_flush_left > 0)) || m_ack;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_flush_left = 0;
            m_jump_en    = 1'b0;
            m_addr       = '0;
            m_ack        = 1'b0;
            m_rcnt       = '0;
            m_hcnt       = '0;
        end else begin
            m_rcnt    = m_rcnt + {31'd0, m_jump_en};
            m_hcnt    = m_hcnt + {31'd0, exp_hold()};
            m_jump_en = 1'b0;
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (m_ack) begin
                m_ack = bif.bus_hold_req;
            end else if (bif.jump_en2ctrl) begin
                m_jump_en    = 1'b1;
                m_addr       = bif.jump_addr2ctrl;
                m_flush_left = FC;
            end else if (bif.bus_hold_req) begin
                m_ack = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("jump_en2pc",   {31'd0, bif.jump_en2pc},   {31'd0, m_jump_en});
        check("jump_addr2pc", bif.jump_addr2pc,          m_addr);
        check("flush2pipe",   {31'd0, bif.flush2pipe},   {31'd0, (m_flush_left > 0)});
        check("bus_hold_ack", {31'd0, bif.bus_hold_ack}, {31'd0, m_ack});
        check("hold_flag",    {31'd0, bif.hold_flag},    {31'd0, exp_hold()});
`ifdef CTRL_STATS_EN
        check("redirect_cnt", redirect_cnt, m_rcnt);
        check("hold_cnt",     hold_cnt,     m_hcnt);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bif.jump_en2ctrl = 1'b0;
        bif.hold2ctrl    = 1'b0;
        bif.bus_hold_req = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        rst                = 1'b1;
        bif.jump_en2ctrl   = 1'b0;
        bif.jump_addr2ctrl = '0;
        bif.hold2ctrl      = 1'b0;
        bif.bus_hold_req   = 1'b0;
        repeat (2) step();
        check("rst jump_en2pc", {31'd0, bif.jump_en2pc},   32'd0);
        check("rst addr",       bif.jump_addr2pc,          32'd0);
        check("rst flush",      {31'd0, bif.flush2pipe},   32'd0);
        check("rst ack",        {31'd0, bif.bus_hold_ack}, 32'd0);
        #3 rst = 1'b0;
        idle(2);

        // Single redirect: one pulse, flush high exactly FC cycles
        bif.jump_en2ctrl = 1'b1; bif.jump_addr2ctrl = 32'h0000_0040;
        step();
        bif.jump_en2ctrl = 1'b0;
        check("redir pulse", {31'd0, bif.jump_en2pc}, 32'd1);
        check("redir addr",  bif.jump_addr2pc,        32'h40);
        check("redir flush1", {31'd0, bif.flush2pipe}, 32'd1);
        step();
        check("redir single", {31'd0, bif.jump_en2pc}, 32'd0);
        check("redir flush2", {31'd0, bif.flush2pipe}, 32'd1);
        step();
        check("redir flush3", {31'd0, bif.flush2pipe}, 32'd0);
        check("redir addr hold", bif.jump_addr2pc,     32'h40);
        idle(2);

        // Back-to-back requests: only first and the one seen after flush
        bif.jump_en2ctrl = 1'b1; bif.jump_addr2ctrl = 32'h40;
        step();
        check("b2b pulse1", {31'd0, bif.jump_en2pc}, 32'd1);
        check("b2b addr1",  bif.jump_addr2pc,        32'h40);
        bif.jump_addr2ctrl = 32'h80;
        step();
        check("b2b ign80", {31'd0, bif.jump_en2pc}, 32'd0);
        bif.jump_addr2ctrl = 32'hC0;
        step();
        check("b2b ignC0", {31'd0, bif.jump_en2pc}, 32'd0);
        step();
        check("b2b pulse2", {31'd0, bif.jump_en2pc}, 32'd1);
        check("b2b addr2",  bif.jump_addr2pc,        32'hC0);
        idle(3);

        // Ex hold passes through when no redirect or flush is active
        bif.hold2ctrl = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("exhold flag",  {31'd0, bif.hold_flag},  32'd1);
            check("exhold flush", {31'd0, bif.flush2pipe}, 32'd0);
            step();
        end
        bif.hold2ctrl = 1'b0;
        #1 check("exhold off", {31'd0, bif.hold_flag}, 32'd0);
        idle(1);

        // Redirect beats an ex hold in the same cycle
        bif.hold2ctrl = 1'b1; bif.jump_en2ctrl = 1'b1; bif.jump_addr2ctrl = 32'h300;
        #1 check("jmp+hold flag", {31'd0, bif.hold_flag}, 32'd0);
        step();
        bif.jump_en2ctrl = 1'b0;
        check("jmp+hold pulse", {31'd0, bif.jump_en2pc}, 32'd1);
        check("flush+hold flag", {31'd0, bif.hold_flag}, 32'd0);
        idle(3);

        // Bus request raised during flush is granted only after flush
        bif.jump_en2ctrl = 1'b1; bif.jump_addr2ctrl = 32'h100;
        step();
        bif.jump_en2ctrl = 1'b0; bif.bus_hold_req = 1'b1;
        check("bus in flush a", {31'd0, bif.bus_hold_ack}, 32'd0);
        step();
        check("bus in flush b", {31'd0, bif.bus_hold_ack}, 32'd0);
        step();
        check("bus after flush", {31'd0, bif.bus_hold_ack}, 32'd0);
        step();
        check("bus granted", {31'd0, bif.bus_hold_ack}, 32'd1);
        check("bus hold_flag", {31'd0, bif.hold_flag},  32'd1);
        bif.jump_en2ctrl = 1'b1; bif.jump_addr2ctrl = 32'h200;
        step();
        check("bus ign jump a", {31'd0, bif.jump_en2pc}, 32'd0);
        step();
        check("bus ign jump b", {31'd0, bif.jump_en2pc}, 32'd0);
        bif.jump_en2ctrl = 1'b0; bif.bus_hold_req = 1'b0;
        step();
        check("bus release", {31'd0, bif.bus_hold_ack}, 32'd0);
        idle(2);

        // Asynchronous reset in the middle of a flush
        bif.jump_en2ctrl = 1'b1; bif.jump_addr2ctrl = 32'h1234;
        step();
        bif.jump_en2ctrl = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst pulse", {31'd0, bif.jump_en2pc},   32'd0);
        check("arst flush", {31'd0, bif.flush2pipe},   32'd0);
        check("arst addr",  bif.jump_addr2pc,          32'd0);
        check("arst ack",   {31'd0, bif.bus_hold_ack}, 32'd0);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst no pulse", {31'd0, bif.jump_en2pc}, 32'd0);
        end

`ifdef CTRL_STATS_EN
        // Fresh counters: 3 redirects and 5 hold cycles
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        step();
        check("stats rst r", redirect_cnt, 32'd0);
        check("stats rst h", hold_cnt,     32'd0);
        for (int i = 0; i < 3; i++) begin
            bif.jump_en2ctrl = 1'b1; bif.jump_addr2ctrl = 32'h400 + 32'(i);
            step();
            bif.jump_en2ctrl = 1'b0;
            repeat (3) step();
        end
        bif.hold2ctrl = 1'b1;
        repeat (5) step();
        bif.hold2ctrl = 1'b0;
        check("stats redirect", redirect_cnt, 32'd3);
        check("stats hold",     hold_cnt,     32'd5);
        idle(1);
`endif

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            bif.jump_en2ctrl   = ($urandom_range(0, 99) < 30);
            bif.jump_addr2ctrl = $urandom;
            bif.hold2ctrl      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) bif.bus_hold_req = ~bif.bus_hold_req;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #4 rst = 1'b0;
            end
            step();
        end

        idle(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule : tb_ctrl
`default_nettype wire
